tft_init_sequencer: RTL
=======================

Name: tft_init_sequencer

Overview:
- Runs the TFT panel power-up and configuration sequence by walking a command ROM. Each ROM entry either sends a byte to the serial LCD byte driver or inserts a timed delay.
- Sits between the system controller (start/done) and the serial byte driver (frame/byte handshake). It is the only master of the driver during initialisation.
- Frame boundaries, and therefore chip-select framing, are taken from the ROM's entry type field.

Parameters:
- ADDR_W, 8, ROM address width; the sequence is at most 2^ADDR_W entries.
- DELAY_UNIT, 50000, clk cycles per delay tick (1 ms at 50 MHz).
- DELAY_W, 24, width of the internal delay counter; must hold 255*DELAY_UNIT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  single-cycle pulse that begins the sequence from address 0; ignored unless in IDLE or DONE
- abort_i  in  1  level; forces a return to IDLE at the next legal point (see Behaviour)
- rom_addr_o  out  ADDR_W  ROM address
- rom_data_i  in  10  ROM entry {type[9:8], payload[7:0]}, valid exactly 1 cycle after rom_addr_o changes
- tx_en_o  out  1  held high while a frame is open (driver asserts chip-select)
- tx_data_o  out  8  byte presented to the driver
- tx_valid_o  out  1  tx_data_o is valid
- tx_ready_i  in  1  driver accepts the byte on a cycle where tx_valid_o and tx_ready_i are both high
- tx_last_o  out  1  qualifies tx_data_o as the final byte of the frame (driver stop flag)
- tx_idle_i  in  1  driver has released chip-select after the frame
- busy_o  out  1  high in every state except IDLE and DONE
- done_o  out  1  held high in DONE until the next start_i or rst

Behaviour:
- Reset values: rom_addr_o=0, tx_en_o=0, tx_valid_o=0, tx_last_o=0, tx_data_o=0, busy_o=0, done_o=0, state=IDLE, delay counter=0.
- Entry types:
  - 00 DATA: payload is a byte inside the current frame.
  - 01 LAST: payload is the final byte of the frame.
  - 10 DELAY: wait payload*DELAY_UNIT cycles; a payload of 0 means no wait.
  - 11 END: sequence finished.
- State machine states: IDLE, FETCH, DECODE, SEND, WAIT_IDLE, DELAY, DONE.
- IDLE/DONE, on start_i: rom_addr_o<=0, done_o<=0, go to FETCH.
- FETCH: one cycle covering ROM latency; go to DECODE.
- DECODE: register rom_data_i, then branch on type:
  - DATA or LAST: tx_en_o<=1, tx_data_o<=payload, tx_valid_o<=1, tx_last_o<=(type==01); go to SEND.
  - DELAY: load counter with payload*DELAY_UNIT; go to DELAY.
  - END: done_o<=1; go to DONE.
- SEND: hold tx_data_o, tx_valid_o and tx_last_o stable until tx_ready_i. On accept, tx_valid_o<=0 and rom_addr_o<=rom_addr_o+1.
  - If the byte was LAST: tx_en_o<=0, go to WAIT_IDLE.
  - Otherwise: tx_en_o stays 1, go to FETCH.
- WAIT_IDLE: stay until tx_idle_i=1, then go to FETCH. This guarantees chip-select deassertion between frames.
- DELAY: decrement the counter each cycle. When the counter is 0, rom_addr_o+1 and go to FETCH. A delay of N ticks occupies N*DELAY_UNIT cycles in DELAY; payload 0 spends 1 cycle in DELAY.
- Minimum latency from start_i to the first tx_valid_o is 3 cycles (IDLE, FETCH, DECODE).
- Address wrap: if rom_addr_o equals 2^ADDR_W-1 and that entry is not END, the sequence completes as if END were read, with done_o=1. The address never wraps to 0.
- A DATA byte followed directly by a DELAY or END entry is a ROM format error. The sequencer closes the frame (tx_en_o<=0) before the delay, or before DONE.
- abort_i:
  - In FETCH, DECODE or DELAY: go to IDLE next cycle, tx_en_o=0.
  - In SEND: the pending byte still completes, because a byte the driver has started must not be withdrawn. After the accept, go to WAIT_IDLE with tx_en_o=0, then to IDLE instead of FETCH.
  - done_o is never set by an abort.
- start_i while busy_o=1 is ignored.
- rst in any state: reset values on the next clk edge. The driver is expected to be reset on the same rst.

Decomposition:
- Shared package tft_pkg:
  - entry-type localparams ENT_DATA=2'b00, ENT_LAST=2'b01, ENT_DELAY=2'b10, ENT_END=2'b11
  - state encoding
  - ROM_W=10
- One natural sub-module, tft_delay_timer: load/count/zero flag, parameterised by DELAY_UNIT and DELAY_W. It can be reused for reset-pin timing.
- The ROM contents (tft_init_rom) live outside this block.

Test Plan:
- ROM {00:0x36, 01:0x48, 11:--}, tx_ready_i tied 1, tx_idle_i asserted 4 cycles after LAST → bytes 0x36 then 0x48, tx_last_o high only with 0x48, tx_en_o low during WAIT_IDLE, done_o=1, rom_addr_o=2.
- DELAY_UNIT=4, ROM {10:0x03, 11} → exactly 12 cycles in DELAY, then done_o. Payload 0x00 → 1 cycle in DELAY.
- Backpressure: tx_ready_i low for 10 cycles on byte 0xA5 → tx_data_o=0xA5 and tx_valid_o held stable throughout, rom_addr_o unchanged until accept.
- abort_i asserted mid-DELAY → IDLE next cycle, busy_o=0, done_o=0. abort_i during SEND → byte still accepted, tx_en_o drops, then IDLE.
- ADDR_W=2, ROM of 4 DATA/LAST entries with no END → completes at address 3, done_o=1, no fetch of address 0. Then start_i restarts from address 0.
- rst asserted in SEND → all outputs at reset values next cycle. A following start_i replays the sequence from address 0 identically.

Source files
------------

// File: rtl/tft_pkg.sv
// tft_pkg: entry-type codes, ROM word width and sequencer state encoding shared by the TFT init logic.
package tft_pkg;
    localparam int ROM_W = 10;
    localparam logic [1:0] ENT_DATA  = 2'b00;
    localparam logic [1:0] ENT_LAST  = 2'b01;
    localparam logic [1:0] ENT_DELAY = 2'b10;
    localparam logic [1:0] ENT_END   = 2'b11;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT_IDLE,
        S_DELAY,
        S_DONE
    } state_t;
endpackage

// File: rtl/tft_delay_timer.sv
// tft_delay_timer: loads ticks*DELAY_UNIT and counts down; o_zero marks the final cycle of the wait.
module tft_delay_timer #(
    parameter int DELAY_UNIT = 50000,
    parameter int DELAY_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_ticks,
    output logic       o_zero
);
    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] w_prod;
    assign w_prod = DELAY_W'(i_ticks) * DELAY_W'(DELAY_UNIT);
    assign o_zero = r_cnt == '0;
    // Load one less than the length so a wait of N cycles ends on the cycle the counter reads zero.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= w_prod - DELAY_W'(w_prod != '0);
        else if (!o_zero)
            r_cnt <= r_cnt - DELAY_W'(1);
    end
endmodule

// File: rtl/tft_init_sequencer.sv
// tft_init_sequencer: walks the init command ROM, framing bytes to the serial LCD driver and inserting delays.
module tft_init_sequencer
    import tft_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DELAY_UNIT = 50000,
    parameter int DELAY_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [ROM_W-1:0]  rom_data_i,
    output logic              tx_en_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              tx_last_o,
    input  logic              tx_idle_i,
    output logic              busy_o,
    output logic              done_o
);
    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr, w_addr_inc;
    logic [7:0]        r_tx_data, w_tx_data;
    logic              r_tx_en, w_tx_en, r_tx_valid, w_tx_valid, r_tx_last, w_tx_last;
    logic              r_done, w_done, r_abort, w_abort, r_wrap, w_wrap;
    logic              w_at_end, w_aborting, w_load, w_zero, w_close;
    logic [1:0]        w_type;

    tft_delay_timer #(.DELAY_UNIT(DELAY_UNIT), .DELAY_W(DELAY_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_ticks(rom_data_i[7:0]),
        .o_zero (w_zero)
    );

    always_comb begin
        w_type     = rom_data_i[ROM_W-1:8];
        w_at_end   = &r_addr;
        w_addr_inc = w_at_end ? r_addr : r_addr + ADDR_W'(1);
        w_aborting = r_abort | abort_i;
        w_close    = r_tx_last | w_aborting;
        w_state    = r_state;
        w_addr     = r_addr;
        w_tx_en    = r_tx_en;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_tx_last  = r_tx_last;
        w_done     = r_done;
        w_abort    = r_abort;
        w_wrap     = r_wrap;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (start_i) begin
                w_state = S_FETCH;
                w_addr  = '0;
                w_done  = 1'b0;
                w_abort = 1'b0;
                w_wrap  = 1'b0;
            end
            S_FETCH: begin
                w_state = abort_i ? S_IDLE : S_DECODE;
                w_tx_en = r_tx_en & ~abort_i;
            end
            // Any non-byte entry closes an open frame, covering a DATA byte with no LAST.
            S_DECODE: begin
                w_tx_en = 1'b0;
                if (abort_i)
                    w_state = S_IDLE;
                else if (!w_type[1]) begin
                    w_state    = S_SEND;
                    w_tx_en    = 1'b1;
                    w_tx_data  = rom_data_i[7:0];
                    w_tx_valid = 1'b1;
                    w_tx_last  = w_type == ENT_LAST;
                end else if (w_type == ENT_DELAY) begin
                    w_state = S_DELAY;
                    w_load  = 1'b1;
                end else begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end
            end
            S_SEND: begin
                w_abort = w_aborting;
                if (tx_ready_i) begin
                    w_tx_valid = 1'b0;
                    w_tx_last  = 1'b0;
                    w_addr     = w_addr_inc;
                    w_wrap     = w_at_end;
                    w_tx_en    = ~(w_close | w_at_end);
                    w_state    = w_close ? S_WAIT_IDLE : w_at_end ? S_DONE : S_FETCH;
                    w_done     = ~w_close & w_at_end;
                end
            end
            S_WAIT_IDLE: begin
                w_abort = w_aborting;
                if (tx_idle_i) begin
                    w_state = w_aborting ? S_IDLE : r_wrap ? S_DONE : S_FETCH;
                    w_done  = ~w_aborting & r_wrap;
                end
            end
            S_DELAY: begin
                if (abort_i)
                    w_state = S_IDLE;
                else if (w_zero) begin
                    w_addr  = w_addr_inc;
                    w_state = w_at_end ? S_DONE : S_FETCH;
                    w_done  = w_at_end;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_tx_en    <= w_tx_en;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_tx_last  <= w_tx_last;
            r_done     <= w_done;
            r_abort    <= w_abort;
            r_wrap     <= w_wrap;
        end
    end

    assign rom_addr_o = r_addr;
    assign tx_en_o    = r_tx_en;
    assign tx_data_o  = r_tx_data;
    assign tx_valid_o = r_tx_valid;
    assign tx_last_o  = r_tx_last;
    assign done_o     = r_done;
    assign busy_o     = r_state != S_IDLE && r_state != S_DONE;
endmodule
